uart_tx_fifo: RTL

//   Parametrised UART transmitter with a TX FIFO, a runtime baud divisor and runtime frame format.

---
 rtl/uart_tx_fifo.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a TX FIFO, with a runtime baud divisor and
// a runtime frame format (5..8 data bits, none/even/odd parity, 1 or 2 stop bits).
// Everything runs on one clock.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_wr_en, i_wr_data  FIFO push (dropped when full)
//   i_cfg_div           bit time = i_cfg_div+1 clocks
//   i_cfg_data_bits     00=5 .. 11=8 data bits
//   i_cfg_parity        00/11 none, 01 even, 10 odd
//   i_cfg_stop2         1 = two stop bits
//   i_break_req         (UART_TX_BREAK_EN only) hold txd low at the next frame boundary
//   o_full, o_level     FIFO status
//   o_overflow          1-cycle pulse after a write was rejected because the FIFO was full
//   o_tx_done           1-cycle pulse after the last stop bit of each frame
//   o_idle              FIFO empty and transmitter idle
//   o_txd               serial output, idle high
//
// Build option: define UART_TX_BREAK_EN to add i_break_req and line-break generation.
module uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_wr_en,
  input  logic [7:0]                  i_wr_data,
  input  logic [DIV_WIDTH-1:0]        i_cfg_div,
  input  logic [1:0]                  i_cfg_data_bits,
  input  logic [1:0]                  i_cfg_parity,
  input  logic                        i_cfg_stop2,
`ifdef UART_TX_BREAK_EN
  input  logic                        i_break_req,
`endif
  output logic                        o_full,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_overflow,
  output logic                        o_tx_done,
  output logic                        o_idle,
  output logic                        o_txd
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StMark} state_e;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic          r_overflow;
  logic [PW-1:0] w_level;
  logic          w_full, w_empty, w_push, w_pop;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign w_level = r_wptr - r_rptr;
  assign w_full  = (w_level == PW'(FIFO_DEPTH));
  assign w_empty = (w_level == '0);
  // Room is judged before any same-cycle pop.
  assign w_push  = i_wr_en && !w_full;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_overflow <= i_wr_en && w_full;
    end
  end

  // ---------------------------------------------------------------- transmitter
  state_e               r_state, w_state_d;
  logic [DIV_WIDTH-1:0] r_cnt, w_cnt_d;
  logic [DIV_WIDTH-1:0] r_div, w_div_d;
  logic [7:0]           r_shift, w_shift_d;
  logic [2:0]           r_bit, w_bit_d;
  logic [2:0]           r_last, w_last_d;
  logic                 r_par_en, w_par_en_d;
  logic                 r_par_bit, w_par_bit_d;
  logic                 r_stop2, w_stop2_d;
  logic                 r_stop_idx, w_stop_idx_d;
  logic                 r_txd, w_txd_d;
  logic                 r_tx_done, w_done_d;
  logic                 r_brk, w_brk_d;
  logic                 w_brk_req, w_can_load, w_load, w_bit_end;
  logic [7:0]           w_mask, w_char;

`ifdef UART_TX_BREAK_EN
  assign w_brk_req = i_break_req;
`else
  assign w_brk_req = 1'b0;
`endif

  always_comb begin
    case (i_cfg_data_bits)
      2'b00:   w_mask = 8'h1F;
      2'b01:   w_mask = 8'h3F;
      2'b10:   w_mask = 8'h7F;
      default: w_mask = 8'hFF;
    endcase
  end

  assign w_char     = r_mem[r_rptr[AW-1:0]] & w_mask;
  assign w_bit_end  = (r_cnt == '0);
  // A pending break holds off the next frame at the boundary.
  assign w_can_load = !w_empty && !w_brk_req;

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_div_d      = r_div;
    w_shift_d    = r_shift;
    w_bit_d      = r_bit;
    w_last_d     = r_last;
    w_par_en_d   = r_par_en;
    w_par_bit_d  = r_par_bit;
    w_stop2_d    = r_stop2;
    w_stop_idx_d = r_stop_idx;
    w_txd_d      = r_txd;
    w_done_d     = 1'b0;
    w_brk_d      = r_brk;
    w_load       = 1'b0;
    w_pop        = 1'b0;

    if (!w_bit_end) w_cnt_d = r_cnt - DIV_WIDTH'(1);

    case (r_state)
      StIdle: begin
        if (w_brk_req) begin
          w_txd_d = 1'b0;
          w_brk_d = 1'b1;
        end else if (r_brk) begin
          // Mark-after-break lasts one bit time at the current divisor.
          w_txd_d   = 1'b1;
          w_brk_d   = 1'b0;
          w_cnt_d   = i_cfg_div;
          w_state_d = StMark;
        end else if (!w_empty) begin
          w_load = 1'b1;
        end
      end
      StStart: begin
        if (w_bit_end) begin
          w_txd_d   = r_shift[0];
          w_shift_d = r_shift >> 1;
          w_bit_d   = '0;
          w_cnt_d   = r_div;
          w_state_d = StData;
        end
      end
      StData: begin
        if (w_bit_end) begin
          w_cnt_d = r_div;
          if (r_bit == r_last) begin
            w_stop_idx_d = 1'b0;
            if (r_par_en) begin
              w_txd_d   = r_par_bit;
              w_state_d = StParity;
            end else begin
              w_txd_d   = 1'b1;
              w_state_d = StStop;
            end
          end else begin
            w_bit_d   = r_bit + 3'd1;
            w_txd_d   = r_shift[0];
            w_shift_d = r_shift >> 1;
          end
        end
      end
      StParity: begin
        if (w_bit_end) begin
          w_txd_d   = 1'b1;
          w_cnt_d   = r_div;
          w_state_d = StStop;
        end
      end
      StStop: begin
        if (w_bit_end) begin
          if (r_stop2 && !r_stop_idx) begin
            w_stop_idx_d = 1'b1;
            w_cnt_d      = r_div;
          end else begin
            w_done_d = 1'b1;
            if (w_can_load) w_load = 1'b1;
            else            w_state_d = StIdle;
          end
        end
      end
      StMark: begin
        if (w_bit_end) begin
          if (w_can_load) w_load = 1'b1;
          else            w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Frame start: pop and snapshot the format so mid-frame cfg changes wait a frame.
    if (w_load) begin
      w_pop       = 1'b1;
      w_state_d   = StStart;
      w_txd_d     = 1'b0;
      w_cnt_d     = i_cfg_div;
      w_div_d     = i_cfg_div;
      w_shift_d   = w_char;
      w_last_d    = {1'b1, i_cfg_data_bits};
      w_par_en_d  = ^i_cfg_parity;
      w_par_bit_d = (^w_char) ^ i_cfg_parity[1];
      w_stop2_d   = i_cfg_stop2;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_div      <= '0;
      r_shift    <= '0;
      r_bit      <= '0;
      r_last     <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_idx <= 1'b0;
      r_txd      <= 1'b1;
      r_tx_done  <= 1'b0;
      r_brk      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_div      <= w_div_d;
      r_shift    <= w_shift_d;
      r_bit      <= w_bit_d;
      r_last     <= w_last_d;
      r_par_en   <= w_par_en_d;
      r_par_bit  <= w_par_bit_d;
      r_stop2    <= w_stop2_d;
      r_stop_idx <= w_stop_idx_d;
      r_txd      <= w_txd_d;
      r_tx_done  <= w_done_d;
      r_brk      <= w_brk_d;
    end
  end

  assign o_full     = w_full;
  assign o_level    = w_level;
  assign o_overflow = r_overflow;
  assign o_tx_done  = r_tx_done;
  assign o_idle     = w_empty && (r_state == StIdle) && !r_brk;
  assign o_txd      = r_txd;

endmodule
